// File: rtl/lsu_mem_port.sv
// MEM-stage load/store unit: formats stores into byte-enabled word writes, runs the
// req/ack data-bus handshake, extends load data, and stalls the pipeline while busy.
module lsu_mem_port #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] memData,
  output logic        load_valid,
  output logic        misalign,
  output logic        bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          we_q, flushed_q, err_q, misalign_q;
  logic [2:0]    funct3_q;
  logic [1:0]    off_q;
  logic          req_q, busWe_q;
  logic [31:0]   busAddr_q, busWdata_q, memData_q;
  logic [3:0]    busBe_q;

  logic          illegal, misaligned, accept, reqBad, timeoutHit;
  logic [3:0]    beFmt;
  logic [31:0]   wdFmt, shifted, loadFmt;

  always_comb begin
    illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (funct3[2] && mem_we);
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    accept     = (state_q == IDLE) && mem_req && !flush && !illegal && !misaligned;
    reqBad     = (state_q == IDLE) && mem_req && !flush && (illegal || misaligned);
    timeoutHit = (TIMEOUT != 0) && (int'(cnt_q) == TIMEOUT - 1);
  end

  // Store lane steering; loads always read the full word.
  always_comb begin
    beFmt = 4'b1111;
    wdFmt = wdata;
    case (funct3[1:0])
      2'b00: begin
        beFmt = 4'b0001 << addr[1:0];
        wdFmt = {4{wdata[7:0]}};
      end
      2'b01: begin
        beFmt = addr[1] ? 4'b1100 : 4'b0011;
        wdFmt = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    if (!mem_we) beFmt = 4'b1111;
  end

  always_comb begin
    shifted = dbus_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  loadFmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  loadFmt = {24'd0, shifted[7:0]};
      3'b001:  loadFmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  loadFmt = {16'd0, shifted[15:0]};
      default: loadFmt = dbus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (dbus_ack || timeoutHit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall      = accept || (state_q == BUSY);
    load_valid = (state_q == RESP) && !we_q && !flushed_q && !flush && !err_q;
    bus_err    = (state_q == RESP) && err_q;
    misalign   = misalign_q;
    memData    = memData_q;
    dbus_req   = req_q;
    dbus_we    = busWe_q;
    dbus_addr  = busAddr_q;
    dbus_be    = busBe_q;
    dbus_wdata = busWdata_q;
  end

  // A flush in BUSY only marks the result dead; the request stays up until ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      we_q       <= 1'b0;
      flushed_q  <= 1'b0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      req_q      <= 1'b0;
      busWe_q    <= 1'b0;
      busAddr_q  <= 32'd0;
      busBe_q    <= 4'd0;
      busWdata_q <= 32'd0;
      memData_q  <= 32'd0;
    end else begin
      misalign_q <= reqBad;
      if (accept) begin
        req_q      <= 1'b1;
        busWe_q    <= mem_we;
        busAddr_q  <= {addr[31:2], 2'b00};
        busBe_q    <= beFmt;
        busWdata_q <= wdFmt;
        we_q       <= mem_we;
        funct3_q   <= funct3;
        off_q      <= addr[1:0];
        cnt_q      <= '0;
        flushed_q  <= 1'b0;
        err_q      <= 1'b0;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + 1'b1;
        if (flush) flushed_q <= 1'b1;
        if (dbus_ack) begin
          req_q <= 1'b0;
          if (!we_q) memData_q <= loadFmt;
        end else if (timeoutHit) begin
          req_q     <= 1'b0;
          err_q     <= 1'b1;
          memData_q <= 32'd0;
        end
      end
    end
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit sitting in the MEM stage of the pipelined RISC-V core, between the ALU result/rs2 operands and the data-memory bus. It formats stores into byte-enabled word writes and runs a req/ack handshake with data memory. It extracts and sign/zero-extends load data into `memData`, the word the writeback select logic forwards to the register file for load instructions. It stalls the pipeline while a bus transaction is outstanding and flags misaligned accesses and bus timeouts.

## Interface
Parameters:
- `TIMEOUT`, 255, max BUSY cycles waiting for `dbus_ack`; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem_req`  in  1  MEM-stage instruction is a load/store.
- `mem_we`  in  1  1 = store, 0 = load.
- `funct3`  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `addr`  in  32  effective address (ALU output).
- `wdata`  in  32  store data (rs2).
- `flush`  in  1  squash the current MEM instruction.
- `stall`  out  1  hold IF–MEM stages.
- `memData`  out  32  formatted load result.
- `load_valid`  out  1  one-cycle pulse: `memData` valid.
- `misalign`  out  1  one-cycle pulse: misaligned or illegal `funct3`.
- `bus_err`  out  1  one-cycle pulse: timeout expired.
- `dbus_req`, `dbus_we`  out  1 each  bus request / write.
- `dbus_addr`  out  32  word address, `addr[31:2]`, low bits 00.
- `dbus_be`  out  4  byte enables.
- `dbus_wdata`  out  32  lane-replicated store data.
- `dbus_ack`  in  1  bus completes the transaction this cycle.
- `dbus_rdata`  in  32  read word, valid with `dbus_ack`.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE + `mem_req` + legal + aligned + !`flush`:
  - latch `addr`, `we`, `funct3`, `wdata`;
  - `stall`=1 combinationally;
  - next state BUSY.
- IDLE + `mem_req` + (misaligned or illegal `funct3`) + !`flush`:
  - `misalign` pulses the next cycle;
  - no bus request, no stall, stay IDLE.
- Misaligned: H/HU/SH with `addr[0]`=1; W/SW with `addr[1:0]`≠00.
- Illegal `funct3`: 011, 110, 111; also 100/101 with `mem_we`=1.
- BUSY:
  - `dbus_req`=1, `stall`=1, bus outputs held stable;
  - wait counter increments each cycle;
  - on `dbus_ack`, register formatted load data and go to RESP.
- RESP:
  - `stall`=0, `dbus_req`=0;
  - `load_valid`=1 for loads only, and only if not flushed;
  - `mem_req` is ignored (same instruction); next state IDLE.
- Store lanes:
  - SB: `dbus_be` = 0001 << `addr[1:0]`, `dbus_wdata` = byte replicated ×4.
  - SH: `dbus_be` = `addr[1]` ? 1100 : 0011, halfword replicated ×2.
  - SW: `dbus_be` = 1111.
  - Loads: `dbus_be` = 1111.
- Load extract:
  - select byte/half by `addr[1:0]`;
  - B/H sign-extend, BU/HU zero-extend, W pass-through.
- `flush` in BUSY:
  - the transaction must complete (req never dropped before ack);
  - `load_valid` is suppressed in RESP.
- Timeout:
  - counter reaches `TIMEOUT` without ack → deassert req, go RESP;
  - `bus_err` pulses, `memData`=0, `load_valid`=0.
- Counter clears on entering BUSY.

## Timing
- Reset (async assert, sync release):
  - state IDLE;
  - `dbus_req`, `dbus_we`, `dbus_addr`, `dbus_be`, `dbus_wdata` = 0;
  - `memData`=0, `load_valid`/`misalign`/`bus_err`/`stall` = 0.
- Reset mid-BUSY drops `dbus_req` immediately; memory side must tolerate an abandoned request.
- Bus outputs are registered, driven from the first BUSY cycle.
- Minimum load latency with ack in the first BUSY cycle:
  - 3 cycles from accept to `load_valid`;
  - `stall` high for 2 cycles (accept, BUSY).
- Each extra wait cycle adds one stall cycle.
- `memData` holds its value until the next load completes.
- Back-to-back accesses: the next access can be accepted in the cycle after RESP.

## Test plan
- LW, `addr`=0x100, `dbus_rdata`=0xDEADBEEF, ack in 1st BUSY cycle → `dbus_be`=1111, `dbus_addr`=0x100, stall 2 cycles, `memData`=0xDEADBEEF with `load_valid` on cycle 3.
- LB vs LBU, `addr`=0x103, `dbus_rdata`=0x80FF0000 → `memData`=0xFFFFFF80 / 0x00000080. LH, `addr`=0x102 → 0xFFFF80FF.
- SB, `addr`=0x201, `wdata`=0x000000A5 → `dbus_we`=1, `dbus_be`=0010, `dbus_wdata`=0xA5A5A5A5. SH, `addr`=0x202, `wdata`=0x1234 → `dbus_be`=1100, `dbus_wdata`=0x12341234.
- LW at 0x102 and SH at 0x201 → `misalign` pulse, `dbus_req` never asserted, `stall` never asserted.
- `TIMEOUT`=4, no ack → `dbus_req` high 4 cycles, then `bus_err` pulse, `memData`=0, no `load_valid`, pipeline released.
- Load with ack after 3 waits, `flush` during BUSY → req held until ack, no `load_valid`. Separately, `rst_n` low mid-BUSY → all outputs 0 at once, next access accepted normally.
